// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop input synchronizer, 2-of-3 majority bit
// sampling, optional even/odd parity, one-cycle result/error pulses.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
    localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state;
    logic [1:0]              sync_q;
    logic [PRESCALE_W-1:0]   edge_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [PRESCALE_W-1:0]   presc_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [1:0]              samp_q;
    logic                    par_bad_q;
    logic                    stp_bad_q;
    logic                    armed_q;

    logic                    rx_s;
    logic [PRESCALE_W-1:0]   half;
    logic                    at_s0, at_s1, at_s2, at_end;
    logic                    maj;

    assign rx_s   = sync_q[1];
    assign half   = presc_q >> 1;
    assign at_s0  = (edge_cnt == half - ONE);
    assign at_s1  = (edge_cnt == half);
    assign at_s2  = (edge_cnt == half + ONE);
    assign at_end = (edge_cnt == presc_q - ONE);
    // Third vote is the live sample taken at PRESCALE/2+1.
    assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: synchronizer resets to the idle line level so reset release never looks like a start bit.
            sync_q     <= 2'b11;
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            shift_q    <= '0;
            samp_q     <= '0;
            par_bad_q  <= 1'b0;
            stp_bad_q  <= 1'b0;
            armed_q    <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], RX_IN};
            // NOTE: pulses default low every cycle and are only raised at frame end; later assignments win.
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= at_end ? '0 : edge_cnt + ONE;
                if (at_s0) samp_q[0] <= rx_s;
                if (at_s1) samp_q[1] <= rx_s;
            end

            case (state)
                IDLE: begin
                    // A start is accepted only once the line has been seen high since the last frame.
                    if (!rx_s && armed_q) begin
                        state     <= START;
                        presc_q   <= PRESCALE;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        edge_cnt  <= ONE;
                        bit_cnt   <= '0;
                        par_bad_q <= 1'b0;
                        stp_bad_q <= 1'b0;
                    end else if (rx_s) begin
                        armed_q <= 1'b1;
                    end
                end
                START: begin
                    if (at_s2 && maj) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        armed_q  <= 1'b0;
                    end else if (at_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (at_s2) shift_q <= {maj, shift_q[DATA_WIDTH-1:1]};
                    if (at_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (at_s2) par_bad_q <= maj ^ (^shift_q) ^ par_typ_q;
                    if (at_end) state <= STOP;
                end
                STOP: begin
                    if (at_s2) stp_bad_q <= ~maj;
                    if (at_end) begin
                        state   <= IDLE;
                        armed_q <= ~stp_bad_q;
                        if (!par_bad_q && !stp_bad_q) begin
                            DATA_VALID <= 1'b1;
                            P_DATA     <= shift_q;
                        end else begin
                            PAR_ERR <= par_bad_q;
                            STP_ERR <= stp_bad_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level model predicts the exact cycle and
// kind of every output pulse; one process compares all outputs every cycle.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] d;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        ev_c;
    logic [7:0] exp_pdata = 8'h00;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    int         last_dv_cyc = 0, prev_dv_cyc = 0;
    int         last_e0 = 0;
    bit         exp_dv, exp_pe, exp_se;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    // Per-cycle comparison against the frame model, sampled mid-cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            exp_dv = 1'b0;
            exp_pe = 1'b0;
            exp_se = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ev_c   = exp_q.pop_front();
                exp_dv = ev_c.dv;
                exp_pe = ev_c.pe;
                exp_se = ev_c.se;
                if (ev_c.dv) exp_pdata = ev_c.d;
            end
            check("outputs{dv,pe,se,pdata}", {21'd0, DATA_VALID, PAR_ERR, STP_ERR, P_DATA},
                  {21'd0, exp_dv, exp_pe, exp_se, exp_pdata});
            if (DATA_VALID) begin
                prev_dv_cyc = last_dv_cyc;
                last_dv_cyc = cyc;
                dv_cnt++;
            end
            if (PAR_ERR) pe_cnt++;
            if (STP_ERR) se_cnt++;
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Called at a negedge. Posts the expected outcome, then serialises the frame.
    task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                              input bit pbit, input bit sbit, input bit scramble, input int abort_at);
        logic fr [0:10];
        int   n;
        int   e0;
        ev_t  ev;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[1+i] = d[i];
        n = 9;
        if (pe) begin
            fr[n] = pbit;
            n++;
        end
        fr[n] = sbit;
        n++;
        PRESCALE = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        // Posedge cyc+1 is the first to sample the line low; result lands N*P+1 edges later.
        e0      = cyc + 1;
        last_e0 = e0;
        ev.cyc  = e0 + n * p + 1;
        ev.pe   = pe && (pbit != ((^d) ^ pt));
        ev.se   = !sbit;
        ev.dv   = !ev.pe && !ev.se;
        ev.d    = d;
        exp_q.push_back(ev);
        for (int i = 0; i < n; i++) begin
            RX_IN = fr[i];
            if (i == abort_at) begin
                repeat (p / 2) @(negedge CLK);
                #2 RST = 1'b1;
                exp_q.delete();
                exp_pdata = 8'h00;
                #1 check("reset_abort_outputs", {21'd0, DATA_VALID, PAR_ERR, STP_ERR, P_DATA}, 32'd0);
                RX_IN = 1'b1;
                repeat (3) @(negedge CLK);
                #2 RST = 1'b0;
                return;
            end
            repeat (p) @(negedge CLK);
            if (scramble && i == 0) begin
                PRESCALE = (p == 8) ? 6'd16 : 6'd8;
                PAR_EN   = !pe;
                PAR_TYP  = !pt;
            end
        end
    endtask

    initial begin
        RST      = 1'b1;
        RX_IN    = 1'b1;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_state", {21'd0, DATA_VALID, PAR_ERR, STP_ERR, P_DATA}, 32'd0);
        #2 RST = 1'b0;
        idle(20);

        // 0xA5, P=8, no parity: pulse in the 82nd cycle counting the sampling edge's cycle as 1st.
        send_frame(8, 0, 0, 8'hA5, 0, 1, 0, -1);
        idle(10);
        check("a5_pdata", {24'd0, P_DATA}, 32'h0000_00A5);
        check("a5_latency", last_dv_cyc - last_e0, 81);
        check("a5_dv_count", dv_cnt, 1);
        check("a5_no_errors", pe_cnt + se_cnt, 0);

        // 0x3C, P=16, even parity, good parity bit; inputs scrambled mid-frame.
        send_frame(16, 1, 0, 8'h3C, 0, 1, 1, -1);
        idle(10);
        check("3c_pdata", {24'd0, P_DATA}, 32'h0000_003C);
        // Same frame with the wrong parity bit.
        send_frame(16, 1, 0, 8'h3C, 1, 1, 0, -1);
        idle(10);
        check("3c_parerr_count", pe_cnt, 1);
        check("3c_parerr_pdata_held", {24'd0, P_DATA}, 32'h0000_003C);
        check("3c_dv_count", dv_cnt, 2);

        // 0x01, P=32, odd parity (bit 0 correct), stop bit low.
        send_frame(32, 1, 1, 8'h01, 0, 0, 0, -1);
        idle(20);
        check("01_stperr_count", se_cnt, 1);
        check("01_no_parerr", pe_cnt, 1);

        // 3-cycle glitch at P=16 must be rejected.
        PRESCALE = 6'd16;
        RX_IN    = 1'b0;
        repeat (3) @(negedge CLK);
        idle(40);
        check("glitch_no_pulse", dv_cnt + pe_cnt + se_cnt, 4);
        send_frame(16, 0, 0, 8'h5A, 0, 1, 0, -1);
        idle(10);
        check("5a_pdata", {24'd0, P_DATA}, 32'h0000_005A);

        // Back-to-back frames at P=8.
        send_frame(8, 0, 0, 8'h11, 0, 1, 0, -1);
        send_frame(8, 0, 0, 8'hEE, 0, 1, 0, -1);
        idle(10);
        check("b2b_spacing", last_dv_cyc - prev_dv_cyc, 80);
        check("b2b_pdata", {24'd0, P_DATA}, 32'h0000_00EE);
        check("b2b_dv_count", dv_cnt, 5);

        // Reset during data bit 4 (frame slot 5), then a clean frame.
        send_frame(8, 0, 0, 8'hF0, 0, 1, 0, 5);
        idle(20);
        check("abort_no_pulse", dv_cnt, 5);
        send_frame(8, 0, 0, 8'h77, 0, 1, 0, -1);
        idle(10);
        check("77_pdata", {24'd0, P_DATA}, 32'h0000_0077);

        // Break: line held low well beyond one frame; one stop error, no re-trigger.
        send_frame(8, 0, 0, 8'h00, 0, 0, 0, -1);
        repeat (40) @(negedge CLK);
        idle(30);
        check("break_stperr_count", se_cnt, 2);
        send_frame(8, 0, 0, 8'hC3, 0, 1, 0, -1);
        idle(30);
        check("c3_pdata", {24'd0, P_DATA}, 32'h0000_00C3);
        check("final_dv_count", dv_cnt, 7);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame, sent LSB first.
REQ-002 Parameter PRESCALE_W, default 6, width of the PRESCALE port.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-high.
REQ-005 RX_IN  input  1  serial line; idles high; asynchronous to CLK.
REQ-006 PRESCALE  input  PRESCALE_W  CLK cycles per bit; legal values are 8, 16 and 32; other values are undefined behaviour.
REQ-007 PAR_EN  input  1  1 means the frame carries a parity bit after the data bits.
REQ-008 PAR_TYP  input  1  parity type: 0 = even, 1 = odd.
REQ-009 P_DATA  output  DATA_WIDTH  last received data word.
REQ-010 DATA_VALID  output  1  one-cycle pulse when P_DATA is updated with a good frame.
REQ-011 PAR_ERR  output  1  one-cycle pulse when a frame ends with a parity mismatch.
REQ-012 STP_ERR  output  1  one-cycle pulse when a frame ends with a stop bit sampled low.

Function
REQ-013 RX_IN SHALL pass through a 2-flop synchronizer; both flops reset to 1; all logic below uses the synchronizer output (rx_s).
REQ-014 The FSM SHALL have exactly these states: IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE: on rx_s==0, the block SHALL capture PRESCALE, PAR_EN and PAR_TYP, enter START, and count that cycle as oversample count 0.
REQ-016 Settings captured at start detection SHALL govern the whole frame; input changes mid-frame SHALL have no effect until the next frame.
REQ-017 Per bit, an edge counter SHALL run 0..PRESCALE-1 and then wrap to 0 as the bit counter advances.
REQ-018 Each bit value SHALL be the 2-of-3 majority of rx_s at counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
REQ-019 START: if the start-bit majority is 1, the block SHALL treat it as a glitch, return to IDLE at the end of that sample window, and pulse no output.
REQ-020 START to DATA SHALL occur at count PRESCALE-1.
REQ-021 DATA: after DATA_WIDTH bits, the block SHALL enter PARITY if the captured PAR_EN is 1, else STOP.
REQ-022 Data bits SHALL be shifted LSB first into an internal shift register, not into P_DATA.
REQ-023 PARITY: a parity error SHALL be flagged when the sampled bit differs from (XOR of data) XOR PAR_TYP.
REQ-024 STOP: a stop error SHALL be flagged when the stop-bit majority is 0.
REQ-025 At STOP count PRESCALE-1, the block SHALL register all of the following for exactly one cycle, then return to IDLE:
  - DATA_VALID=1 and P_DATA=shift register, if there is no error;
  - otherwise PAR_ERR and/or STP_ERR=1, with DATA_VALID=0 and P_DATA unchanged.
REQ-026 Latency: DATA_VALID (or the error pulse) SHALL be high in the cycle N*PRESCALE+2 after the first CLK edge that samples RX_IN low, where N=1+DATA_WIDTH+PAR_EN+1.
REQ-027 Back-to-back frames: a start bit beginning in the cycle after the STOP-to-IDLE transition SHALL be detected with no lost frame.
REQ-028 An RX_IN held low (break) SHALL produce STP_ERR and then re-arm only after rx_s returns high, i.e. IDLE SHALL require seeing rx_s==1 before accepting a new start.
REQ-029 DATA_VALID, PAR_ERR and STP_ERR SHALL never be high for two consecutive cycles.

Reset
REQ-030 RST=1 SHALL immediately force: state=IDLE, counters=0, shift register=0, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, synchronizer flops=1.
REQ-031 RST asserted mid-frame SHALL abort the frame with no output pulse; reception SHALL resume from IDLE after release.

Verification
REQ-032 PRESCALE=8, PAR_EN=0, send 0xA5 -> DATA_VALID pulses once 82 cycles after the falling edge; P_DATA=0xA5; no error pulse.
REQ-033 PRESCALE=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> P_DATA=0x3C, DATA_VALID=1; then send with parity bit 1 -> PAR_ERR pulse, DATA_VALID=0, P_DATA stays 0x3C.
REQ-034 PRESCALE=32, PAR_EN=1, PAR_TYP=1, send 0x01 with stop bit 0 -> STP_ERR pulse; PAR_ERR=0 for parity bit 0.
REQ-035 RX_IN low pulse of 3 cycles at PRESCALE=16 -> no pulses, FSM back in IDLE; a following frame 0x5A is received correctly.
REQ-036 Two frames 0x11 and 0xEE back-to-back at PRESCALE=8 -> two DATA_VALID pulses 80 cycles apart with the correct data.
REQ-037 RST asserted during DATA bit 4 -> all outputs 0 within the same cycle, no pulse; the next frame 0x77 is received correctly.
